// File: rtl/uart_rx_fifo.sv
// UART byte receiver (8N1, LSB first) feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an extra PARITY state.
module uart_rx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ena,
   input  logic                          rx,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          frame_err,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned CNT_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned FCNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   logic              rx_meta_q;
   logic              rxs_q;
   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        bit_q;
   logic [7:0]        shift_q;
   logic              frame_err_q;
`ifdef UART_RX_PARITY_EN
   logic              par_err_q;
`endif

   logic              sample_c;
   logic              push_c;

   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wptr_q;
   logic [PTR_W-1:0]  rptr_q;
   logic [FCNT_W-1:0] count_q;
   logic [FCNT_W-1:0] count_d;
   logic              overrun_q;
   logic              overrun_d;
   logic              full_c;
   logic              pop_c;
   logic              push_ok_c;

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rxs_q     <= rx_meta_q;
      end
   end

   always_comb begin
      sample_c = (cnt_q == BIT_LAST);
      push_c   = 1'b0;
      if (ena && (state_q == S_STOP) && sample_c && rxs_q) begin
`ifdef UART_RX_PARITY_EN
         push_c = ~par_err_q;
`else
         push_c = 1'b1;
`endif
      end
   end

   // Frame FSM: counter restarts at every sample point so each bit is centred.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         frame_err_q <= 1'b0;
         if (!ena) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (!rxs_q) begin
                     cnt_q   <= '0;
                     state_q <= S_START;
                  end
               end
               S_START: begin
                  if (cnt_q == HALF_LAST) begin
                     cnt_q   <= '0;
                     bit_q   <= '0;
                     state_q <= rxs_q ? S_IDLE : S_DATA;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               S_DATA: begin
                  if (sample_c) begin
                     cnt_q   <= '0;
                     shift_q <= {rxs_q, shift_q[7:1]};
                     bit_q   <= bit_q + 3'd1;
                     if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= S_PARITY;
`else
                        state_q <= S_STOP;
`endif
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
`ifdef UART_RX_PARITY_EN
               S_PARITY: begin
                  if (sample_c) begin
                     cnt_q     <= '0;
                     par_err_q <= ^{shift_q, rxs_q};
                     state_q   <= S_STOP;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
`endif
               S_STOP: begin
                  if (sample_c) begin
                     cnt_q <= '0;
                     if (!rxs_q) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_WAIT_HIGH;
                     end else begin
`ifdef UART_RX_PARITY_EN
                        frame_err_q <= par_err_q;
`endif
                        state_q     <= S_IDLE;
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               S_WAIT_HIGH: begin
                  if (rxs_q) begin
                     state_q <= S_IDLE;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   always_comb begin
      full_c    = (count_q == FULL_CNT);
      pop_c     = rx_valid & rx_ready;
      push_ok_c = push_c & (~full_c | pop_c);
      overrun_d = push_c & full_c & ~pop_c;
      count_d   = count_q;
      case ({push_ok_c, pop_c})
         2'b10:   count_d = count_q + FCNT_W'(1);
         2'b01:   count_d = count_q - FCNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         if (push_ok_c) begin
            mem_q[wptr_q] <= shift_q;
            wptr_q        <= wptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rptr_q <= rptr_q + PTR_W'(1);
         end
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   assign rx_valid   = (count_q != '0);
   assign rx_data    = mem_q[rptr_q];
   assign fifo_count = count_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame table plus hand sequences, with a byte scoreboard on pops.
module tb_uart_rx_fifo;

   localparam int unsigned CPB   = 16;
   localparam int unsigned DEPTH = 4;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 171;
`else
   localparam int LAT = 155;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic [$clog2(DEPTH):0] fifo_count;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .ena(ena), .rx(rx),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_err(frame_err), .overrun(overrun), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every handshake pops the oldest expected byte.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) fe_cnt++;
         if (overrun)   ov_cnt++;
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop: got 0x%0h, expected no byte", rx_data);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("pop_data", int'(rx_data), int'(mon_exp));
            end
         end
      end
   end

   task automatic send_frame(input logic [7:0] d, input logic stop_b,
                             input logic par_bad, input int extra_low);
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rx = d[i];
         repeat (CPB) @(posedge clk);
      end
`ifdef UART_RX_PARITY_EN
      #1 rx = (^d) ^ par_bad;
      repeat (CPB) @(posedge clk);
`endif
      #1 rx = stop_b;
      repeat (CPB + extra_low) @(posedge clk);
      #1 rx = 1'b1;
   endtask

   task automatic pop_one();
      @(posedge clk);
      #1 rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
   endtask

   task automatic wait_count(input int exp, input string name);
      int n = 0;
      while (int'(fifo_count) != exp && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk(name, int'(fifo_count), exp);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       par_bad;
      int         extra_low;
      logic       exp_push;
      int         exp_fe;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int fe0;
      int ov0;

      vecs[0] = '{8'h00, 1'b1, 1'b0, 0,  1'b1, 0};
      vecs[1] = '{8'hFF, 1'b1, 1'b0, 0,  1'b1, 0};
      vecs[2] = '{8'h3C, 1'b1, 1'b0, 0,  1'b1, 0};
      vecs[3] = '{8'h55, 1'b0, 1'b0, 24, 1'b0, 1};
      vecs[4] = '{8'h81, 1'b1, 1'b0, 0,  1'b1, 0};
      vecs[5] = '{8'h7E, 1'b1, 1'b0, 0,  1'b1, 0};
      vecs[6] = '{8'h07, 1'b1, 1'b0, 0,  1'b1, 0};
`ifdef UART_RX_PARITY_EN
      vecs[7] = '{8'h07, 1'b1, 1'b1, 0,  1'b0, 1};
`else
      vecs[7] = '{8'h80, 1'b1, 1'b0, 0,  1'b1, 0};
`endif

      // Reset with idle line.
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", int'(rx_valid), 0);
      chk("rst_data", int'(rx_data), 0);
      chk("rst_frame_err", int'(frame_err), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_count", int'(fifo_count), 0);
      repeat (200) @(negedge clk);
      chk("idle_valid", int'(rx_valid), 0);
      chk("idle_count", int'(fifo_count), 0);
      chk("idle_pulses", fe_cnt + ov_cnt, 0);

      // Single byte with exact latency, then a single pop.
      exp_q.push_back(8'hA5);
      fork
         send_frame(8'hA5, 1'b1, 1'b0, 0);
         begin
            repeat (LAT) @(posedge clk);
            @(negedge clk);
            chk("lat_before", int'(rx_valid), 0);
            @(negedge clk);
            chk("lat_at", int'(rx_valid), 1);
            chk("a5_data", int'(rx_data), 8'hA5);
            chk("a5_count", int'(fifo_count), 1);
         end
      join
      pop_one();
      @(negedge clk);
      chk("a5_pop_valid", int'(rx_valid), 0);
      chk("a5_pop_count", int'(fifo_count), 0);

      // Frame table, consumer always ready.
      #1 rx_ready = 1'b1;
      for (int v = 0; v < 8; v++) begin
         fe0 = fe_cnt;
         if (vecs[v].exp_push) exp_q.push_back(vecs[v].data);
         send_frame(vecs[v].data, vecs[v].stop, vecs[v].par_bad, vecs[v].extra_low);
         repeat (4) @(negedge clk);
         chk($sformatf("vec%0d_frame_err", v), fe_cnt - fe0, vecs[v].exp_fe);
         wait_count(0, $sformatf("vec%0d_count", v));
      end
      chk("table_drained", exp_q.size(), 0);
      @(posedge clk);
      #1 rx_ready = 1'b0;

      // Short low glitch must not start a frame.
      fe0 = fe_cnt;
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (4) @(posedge clk);
      #1 rx = 1'b1;
      repeat (30) @(negedge clk);
      chk("glitch_count", int'(fifo_count), 0);
      chk("glitch_fe", fe_cnt - fe0, 0);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, 1'b0, 0);
      wait_count(1, "after_glitch_count");
      pop_one();
      wait_count(0, "after_glitch_drain");

      // Overrun: fifth byte dropped while nobody pops.
      ov0 = ov_cnt;
      for (int k = 1; k <= 5; k++) begin
         if (k <= 4) exp_q.push_back(8'(k));
         send_frame(8'(k), 1'b1, 1'b0, 0);
      end
      repeat (4) @(negedge clk);
      chk("ovr_pulses", ov_cnt - ov0, 1);
      chk("ovr_count", int'(fifo_count), 4);
      for (int k = 0; k < 4; k++) pop_one();
      wait_count(0, "ovr_drain");

      // Full FIFO with a pop in the same cycle as the push: no overrun.
      ov0 = ov_cnt;
      for (int k = 1; k <= 4; k++) begin
         exp_q.push_back(8'(k));
         send_frame(8'(k), 1'b1, 1'b0, 0);
      end
      chk("full_count", int'(fifo_count), 4);
      exp_q.push_back(8'h05);
      fork
         send_frame(8'h05, 1'b1, 1'b0, 0);
         begin
            repeat (LAT) @(posedge clk);
            #1 rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
         end
      join
      repeat (4) @(negedge clk);
      chk("same_cycle_ovr", ov_cnt - ov0, 0);
      chk("same_cycle_count", int'(fifo_count), 4);
      for (int k = 0; k < 4; k++) pop_one();
      wait_count(0, "same_cycle_drain");
      chk("ovr_drained", exp_q.size(), 0);

      // Enable dropped mid-frame discards the partial byte.
      fe0 = fe_cnt;
      fork
         send_frame(8'hFF, 1'b1, 1'b0, 0);
         begin
            repeat (50) @(posedge clk);
            #1 ena = 1'b0;
            repeat (5) @(posedge clk);
            #1 ena = 1'b1;
         end
      join
      repeat (10) @(negedge clk);
      chk("ena_count", int'(fifo_count), 0);
      chk("ena_fe", fe_cnt - fe0, 0);

      // Reset mid-frame loses the in-flight byte.
      fork
         send_frame(8'hFF, 1'b1, 1'b0, 0);
         begin
            repeat (60) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
         end
      join
      repeat (10) @(negedge clk);
      chk("midrst_count", int'(fifo_count), 0);
      chk("midrst_valid", int'(rx_valid), 0);
      chk("final_queue", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial byte receiver that sits directly upstream of the `tt_um_nhcourse` core logic. It converts the asynchronous UART line arriving on a dedicated input pin into bytes and buffers them in a small first-word-fall-through FIFO. The core drains the FIFO through a valid/ready handshake. Frame is 8N1, LSB first; the baud rate is set by a parameter.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: `clk` cycles per bit. Must be even and ≥ 4.
- `FIFO_DEPTH`, default 4: byte entries. Must be a power of two ≥ 2.

Ports:
- `clk`  in  1: the single clock. All logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset. The top level drives it as `~rst_n`.
- `ena`  in  1: receiver enable. When low, the FSM is forced to IDLE and FIFO contents are kept.
- `rx`  in  1: raw UART line, connected to `ui_in[0]`. Asynchronous to `clk`; idles high.
- `rx_data`  out  8: byte at the FIFO head. Valid only while `rx_valid` = 1.
- `rx_valid`  out  1: high whenever the FIFO is non-empty.
- `rx_ready`  in  1: consumer accept. A pop occurs on any cycle with `rx_valid` & `rx_ready`.
- `frame_err`  out  1: one-cycle pulse when a stop bit is sampled as 0.
- `overrun`  out  1: one-cycle pulse when a completed byte is dropped because the FIFO is full.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: number of bytes currently held.

## Operation

- **Synchronizer:** 2-flop synchronizer on `rx`, both flops reset to 1. All FSM logic uses the synchronized value `rxs`.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH. An internal bit counter counts 0..CLKS_PER_BIT-1.
- **IDLE:** the cycle in which `rxs` = 0 is T0. Clear the counter and go to START.
- **START:** sample `rxs` at T0 + CLKS_PER_BIT/2.
  - If the sample is 1 (glitch), return to IDLE with no output.
  - If the sample is 0, go to DATA.
- **DATA:** sample bit i (i = 0..7) at T0 + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT. Shift into the shift register LSB first.
- **STOP:** sample at T0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
  - Sample = 1: push the byte, return to IDLE.
  - Sample = 0: pulse `frame_err`, drop the byte, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rxs` = 1, then go to IDLE. This covers a break condition and prevents a false start on a held-low line.
- **FIFO:**
  - Circular buffer with read and write pointers and a count.
  - `rx_data` = entry at the read pointer (combinational read of the registered array).
  - Pointers wrap modulo FIFO_DEPTH.
- **Push when full:** the byte is discarded, `overrun` pulses, and FIFO contents are unchanged.
- **Push and pop in the same cycle:** both take effect and the count is unchanged. When full, this push succeeds and no overrun occurs.
- **Pop when empty:** ignored.
- **`ena` deasserted mid-frame:** the partial byte is discarded and the FSM returns to IDLE. A pending push is not produced.

## Timing

- **Reset values:**
  - `rx_data` = 0x00, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, `fifo_count` = 0.
  - FSM in IDLE, synchronizer flops = 1.
- **Pin-to-FSM delay:** 2 cycles from the `rx` pin to `rxs`.
- **Byte latency:** `rx_valid` rises in the cycle after the stop sample, i.e. T0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1. With CLKS_PER_BIT = 16 this is T0 + 153. It is the same for a push into a non-empty FIFO; there `fifo_count` increments instead.
- **Pop:** `fifo_count` decrements and the next head appears on `rx_data` in the cycle after the pop edge.
- **Pulse timing:** `frame_err` and `overrun` are high for exactly the one cycle after the stop sample.
- **Back-to-back frames:** a new start bit is accepted on the first cycle after the return to IDLE.
- **Reset:** asserting `rst` at any time takes effect immediately. It clears all state, and an in-flight byte is lost.

## Configuration

- **`UART_RX_PARITY_EN` defined:**
  - The frame is 8E1. A PARITY state follows DATA and samples at T0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
  - The stop sample moves to … + 10·CLKS_PER_BIT.
  - If data XOR parity bit ≠ 0, the byte is dropped and `frame_err` pulses after the stop sample. The FSM then returns to IDLE, or to WAIT_HIGH if the stop bit was also 0.
  - Latency grows by CLKS_PER_BIT.
- **Undefined:** 8N1 as described above; no PARITY state is synthesized.

## Test plan

CLKS_PER_BIT = 16, FIFO_DEPTH = 4 unless noted.

- **Reset:** pulse `rst` with `rx` = 1 → all outputs 0 and `fifo_count` = 0. Hold 200 cycles → no change.
- **Single byte:** send 0xA5 with `rx_ready` = 0 → `rx_valid` = 1 at T0 + 153, `rx_data` = 0xA5, `fifo_count` = 1. Raise `rx_ready` for 1 cycle → `rx_valid` = 0, `fifo_count` = 0.
- **Glitch:** drive `rx` low for 4 cycles, then high → no push, FSM returns to IDLE. A following 0x3C is received correctly.
- **Framing error:** send 0x55 with the stop bit = 0 and hold `rx` low 40 cycles → one `frame_err` pulse, `fifo_count` stays 0. A following 0x81 is received once `rx` returns high.
- **Overrun:** send 0x01..0x05 with `rx_ready` = 0 → `overrun` pulses once on 0x05, `fifo_count` = 4, pops yield 0x01, 0x02, 0x03, 0x04. Repeat while popping in the same cycle as the 5th push → no overrun.
- **Parity build (`UART_RX_PARITY_EN`):**
  - 0x07 with parity bit 1 → accepted at T0 + 169.
  - 0x07 with parity bit 0 → `frame_err` pulses and no push.
